// File: rtl/des_key_unmixer_if.sv
// rtl/des_key_unmixer_if.sv - subkey stream bundle between key scheduler and round datapath
interface des_key_unmixer_if #(
   parameter int SUBKEY_W = 48,
   parameter int RIDX_W   = 4
);
   logic [SUBKEY_W-1:0] subkey;
   logic [RIDX_W-1:0]   round_idx;
   logic                subkey_valid;
   logic                subkey_ready;

   modport master (
      output subkey,
      output round_idx,
      output subkey_valid,
      input  subkey_ready
   );

   modport slave (
      input  subkey,
      input  round_idx,
      input  subkey_valid,
      output subkey_ready
   );
endinterface

// File: rtl/des_key_unmixer.sv
// rtl/des_key_unmixer.sv - sequential DES key scheduler, K16..K1 (KEYSCHED_ENC_MODE_EN adds K1..K16)
module des_key_unmixer #(
   parameter int KEY_W    = 56,
   parameter int SUBKEY_W = 48,
   parameter int ROUNDS   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [KEY_W-1:0] key_in,
`ifdef KEYSCHED_ENC_MODE_EN
   input  logic             enc_mode,
`endif
   output logic             busy,
   output logic             done,
   des_key_unmixer_if.master sk
);
   localparam int HALF_W = KEY_W / 2;
   localparam int RIDX_W = $clog2(ROUNDS);
   localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(ROUNDS - 1);

   // PC-2 selection, FIPS numbering: entry i gives the 1-based input bit for output bit i+1
   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t              state_q, state_d;
   logic [HALF_W-1:0]   c_q, c_d;
   logic [HALF_W-1:0]   d_q, d_d;
   logic [RIDX_W-1:0]   round_q, round_d;
   logic                fwd;
   logic                last;
   logic                two_step;

   function automatic logic [SUBKEY_W-1:0] pc2(input logic [KEY_W-1:0] cd);
      logic [SUBKEY_W-1:0] res;
      res = '0;
      for (int i = 0; i < SUBKEY_W; i++) begin
         res[SUBKEY_W-1-i] = cd[KEY_W - PC2_TAB[i]];
      end
      return res;
   endfunction

   function automatic logic [HALF_W-1:0] rot_r(input logic [HALF_W-1:0] x, input logic two);
      return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
   endfunction

   function automatic logic [HALF_W-1:0] rot_l(input logic [HALF_W-1:0] x, input logic two);
      return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
   endfunction

   // rounds 1, 2, 9 and 16 (0-based 0, 1, 8, 15) use a single-bit rotation
   function automatic logic is_two(input logic [RIDX_W-1:0] r);
      return !((r == RIDX_W'(0)) || (r == RIDX_W'(1)) || (r == RIDX_W'(8)) || (r == RIDX_W'(15)));
   endfunction

`ifdef KEYSCHED_ENC_MODE_EN
   logic enc_q, enc_d;
   assign fwd = enc_q;
`else
   assign fwd = 1'b0;
`endif

   assign last     = fwd ? (round_q == LAST_IDX) : (round_q == '0);
   assign two_step = fwd ? is_two(round_q + RIDX_W'(1)) : is_two(round_q);

   assign sk.subkey_valid = (state_q == ST_RUN);
   assign sk.subkey       = pc2({c_q, d_q});
   assign sk.round_idx    = round_q;
   assign busy            = (state_q == ST_RUN);
   assign done            = (state_q == ST_DONE);

   // next-state: load on start, step C/D one round per accepted subkey
   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      round_d = round_q;
`ifdef KEYSCHED_ENC_MODE_EN
      enc_d   = enc_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // encryption shifts sum to 28, so K16 is PC-2 of the unrotated halves
               c_d     = key_in[KEY_W-1:HALF_W];
               d_d     = key_in[HALF_W-1:0];
               round_d = LAST_IDX;
               state_d = ST_RUN;
`ifdef KEYSCHED_ENC_MODE_EN
               enc_d = enc_mode;
               if (enc_mode) begin
                  c_d     = rot_l(key_in[KEY_W-1:HALF_W], 1'b0);
                  d_d     = rot_l(key_in[HALF_W-1:0], 1'b0);
                  round_d = '0;
               end
`endif
            end
         end
         ST_RUN: begin
            if (sk.subkey_ready) begin
               if (last) begin
                  state_d = ST_DONE;
               end else if (fwd) begin
                  c_d     = rot_l(c_q, two_step);
                  d_d     = rot_l(d_q, two_step);
                  round_d = round_q + RIDX_W'(1);
               end else begin
                  c_d     = rot_r(c_q, two_step);
                  d_d     = rot_r(d_q, two_step);
                  round_d = round_q - RIDX_W'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // state and key-half registers, cleared immediately on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         c_q     <= '0;
         d_q     <= '0;
         round_q <= '0;
`ifdef KEYSCHED_ENC_MODE_EN
         enc_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         round_q <= round_d;
`ifdef KEYSCHED_ENC_MODE_EN
         enc_q   <= enc_d;
`endif
      end
   end
endmodule

// File: tb/tb_des_key_unmixer.sv
// tb/tb_des_key_unmixer.sv - scoreboard bench for des_key_unmixer
module tb_des_key_unmixer;
   localparam logic [55:0] FIPS_KEY = 56'hF0CCAAF556678F;
   localparam int PC2_REF [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [55:0] key_in;
   logic        busy;
   logic        done;
`ifdef KEYSCHED_ENC_MODE_EN
   logic        enc_mode;
`endif

   des_key_unmixer_if #(.SUBKEY_W(48), .RIDX_W(4)) sk ();

   des_key_unmixer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .key_in (key_in),
`ifdef KEYSCHED_ENC_MODE_EN
      .enc_mode (enc_mode),
`endif
      .busy   (busy),
      .done   (done),
      .sk     (sk.master)
   );

   int          n_checks = 0;
   int          n_fails  = 0;
   int          pops     = 0;
   int          done_cnt = 0;
   logic [51:0] sb [$];
   logic [55:0] cur_key;
   logic        hold_pending;
   logic [51:0] held;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // forward (encryption-order) reference schedule: Kn after n left rotations
   function automatic logic [47:0] ref_key(input logic [55:0] key, input int n);
      logic [27:0] c, d;
      logic [55:0] cd;
      logic [47:0] k;
      c = key[55:28];
      d = key[27:0];
      for (int i = 0; i < n; i++) begin
         for (int s = 0; s < SHIFTS[i]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
      end
      cd = {c, d};
      k = '0;
      for (int i = 0; i < 48; i++) k[47-i] = cd[56 - PC2_REF[i]];
      return k;
   endfunction

   // consumer-side monitor: pops scoreboard on accepted subkeys, checks hold during stalls
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) done_cnt++;
         if (sk.subkey_valid) begin
            if (hold_pending) check("stall_hold", {12'h0, sk.round_idx, sk.subkey}, {12'h0, held});
            if (sk.subkey_ready) begin
               hold_pending = 1'b0;
               pops++;
               if (sb.size() == 0) begin
                  check("sb_underflow", 64'd1, 64'd0);
               end else begin
                  check("subkey", {12'h0, sk.round_idx, sk.subkey}, {12'h0, sb.pop_front()});
               end
               if (cur_key == FIPS_KEY) begin
                  if (sk.round_idx == 4'd15) check("fips_k16", {16'h0, sk.subkey}, 64'hCB3D8B0E17F5);
                  if (sk.round_idx == 4'd1)  check("fips_k2",  {16'h0, sk.subkey}, 64'h79AED9DBC9E5);
                  if (sk.round_idx == 4'd0)  check("fips_k1",  {16'h0, sk.subkey}, 64'h1B02EFFC7072);
               end
            end else begin
               hold_pending = 1'b1;
               held = {sk.round_idx, sk.subkey};
            end
         end
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, {63'h0, sk.subkey_valid}, 64'd0);
      check({tag, "_busy"},  {63'h0, busy}, 64'd0);
      check({tag, "_done"},  {63'h0, done}, 64'd0);
      check({tag, "_ridx"},  {60'h0, sk.round_idx}, 64'd0);
   endtask

   // mode 0: ready always 1; mode 1: random ready with a 5-cycle stall
   // poke: start with another key mid-run; abort_after >= 0: reset after that many transfers
   task automatic run_seq(input logic [55:0] key, input logic enc, input int mode,
                          input logic poke, input int abort_after);
      int cyc;
      int p0;
      int d0;
      logic [63:0] t;
      cur_key = key;
      if (enc) begin
         for (int r = 0; r < 16; r++) sb.push_back({4'(r), ref_key(key, r + 1)});
      end else begin
         for (int r = 15; r >= 0; r--) sb.push_back({4'(r), ref_key(key, r + 1)});
      end
`ifdef KEYSCHED_ENC_MODE_EN
      enc_mode = enc;
`endif
      p0 = pops;
      d0 = done_cnt;
      key_in = key;
      start = 1'b1;
      sk.subkey_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      while (1) begin
         @(negedge clk);
         #1;
         cyc++;
         if (cyc == 1) begin
            check("first_valid", {63'h0, sk.subkey_valid}, 64'd1);
            check("busy_run", {63'h0, busy}, 64'd1);
            check("first_ridx", {60'h0, sk.round_idx}, enc ? 64'd0 : 64'd15);
         end
         if (done) break;
         if (cyc > 300) begin
            check("timeout_done", 64'd0, 64'd1);
            break;
         end
         if (abort_after >= 0 && (pops - p0) >= abort_after) begin
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check_idle("async_rst");
            sb.delete();
            hold_pending = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            return;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (poke && cyc == 5) begin
            start = 1'b1;
            key_in = ~key;
         end
         if (mode == 0) sk.subkey_ready = 1'b1;
         else sk.subkey_ready = (cyc >= 3 && cyc < 8) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      if (mode == 0) check("done_latency", 64'(cyc), 64'd17);
      check("sb_drained", 64'(sb.size()), 64'd0);
      check("pop_count", 64'(pops - p0), 64'd16);
      // start during the DONE cycle must be ignored
      t = {$urandom(), $urandom()};
      key_in = t[55:0];
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check_idle("post_done");
      check("done_once", 64'(done_cnt - d0), 64'd1);
   endtask

   initial begin
      logic [63:0] t;
      rst_n = 1'b0;
      start = 1'b0;
      key_in = '0;
      sk.subkey_ready = 1'b0;
      hold_pending = 1'b0;
      held = '0;
      cur_key = '0;
`ifdef KEYSCHED_ENC_MODE_EN
      enc_mode = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      check("reset_subkey", {16'h0, sk.subkey}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_seq(FIPS_KEY, 1'b0, 0, 1'b0, -1);
      run_seq(FIPS_KEY, 1'b0, 1, 1'b0, -1);
      run_seq(FIPS_KEY, 1'b0, 0, 1'b0, 7);
      run_seq(FIPS_KEY, 1'b0, 0, 1'b0, -1);
      run_seq(FIPS_KEY, 1'b0, 0, 1'b1, -1);
      run_seq(FIPS_KEY, 1'b0, 1, 1'b1, -1);
      for (int k = 0; k < 3; k++) begin
         t = {$urandom(), $urandom()};
         run_seq(t[55:0], 1'b0, 1, 1'b0, -1);
      end
`ifdef KEYSCHED_ENC_MODE_EN
      run_seq(FIPS_KEY, 1'b1, 0, 1'b0, -1);
      t = {$urandom(), $urandom()};
      run_seq(t[55:0], 1'b1, 1, 1'b0, -1);
      run_seq(FIPS_KEY, 1'b0, 0, 1'b0, -1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
